pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Arbitrates the single physical-memory line port between the pipelined instruction cache and the data cache. Each cache issues full-line (256-bit) read or write-back requests as if it owned memory. The arbiter grants one requester at a time, forwards that requester's command to memory, and routes the memory response back only to that requester. It sits between the two caches' pmem interfaces and the cacheline adaptor / main memory model.

## Interface
- `LINE_WIDTH`, default 256: cache line width in bits.
- `ADDR_WIDTH`, default 32: line address width.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `i_pmem_read`  in  1  I-cache line-fill request (level, held until `i_pmem_resp`).
- `i_pmem_address`  in  ADDR_WIDTH  I-cache line address, stable while request is held.
- `i_pmem_rdata`  out  LINE_WIDTH  fill data to I-cache.
- `i_pmem_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_pmem_read`  in  1  D-cache line-fill request.
- `d_pmem_write`  in  1  D-cache write-back request.
- `d_pmem_address`  in  ADDR_WIDTH  D-cache line address.
- `d_pmem_wdata`  in  LINE_WIDTH  write-back data.
- `d_pmem_rdata`  out  LINE_WIDTH  fill data to D-cache.
- `d_pmem_resp`  out  1  one-cycle completion pulse to D-cache.
- `mem_read`, `mem_write`  out  1  downstream command.
- `mem_address`  out  ADDR_WIDTH  downstream address.
- `mem_wdata`  out  LINE_WIDTH  downstream write data.
- `mem_rdata`  in  LINE_WIDTH  downstream read data.
- `mem_resp`  in  1  downstream completion pulse.

## Operation
- States: `ARB_IDLE`, `ARB_ICACHE`, `ARB_DCACHE`. There is also a 1-bit `last_grant` register (0 = I, 1 = D).
- `ARB_IDLE` selection:
  - Only I requests: go to `ARB_ICACHE`.
  - Only D requests (read or write): go to `ARB_DCACHE`.
  - Both request: grant the side opposite `last_grant`. On the first conflict after reset, D wins, because `last_grant` resets to 0.
- On every grant, `last_grant` updates to the granted side.
- In `ARB_ICACHE`:
  - `mem_read` = `i_pmem_read`, `mem_write` = 0.
  - `mem_address` = `i_pmem_address`.
- In `ARB_DCACHE`:
  - `mem_read` = `d_pmem_read`, `mem_write` = `d_pmem_write`.
  - `mem_address` = `d_pmem_address`, `mem_wdata` = `d_pmem_wdata`.
- In `ARB_IDLE`: `mem_read` = `mem_write` = 0, `mem_address` = 0, `mem_wdata` = 0.
- `mem_rdata` is broadcast to both `i_pmem_rdata` and `d_pmem_rdata` at all times. It is valid only when qualified by the corresponding resp.
- Responses:
  - `i_pmem_resp` = `mem_resp` AND (state == `ARB_ICACHE`).
  - `d_pmem_resp` = `mem_resp` AND (state == `ARB_DCACHE`).
  - Both are combinational, and both are 0 in `ARB_IDLE`.
- On `mem_resp` in a serve state, the next state is `ARB_IDLE` unconditionally.
- D-cache dirty miss: write-back and fill are two separate grants. If I is pending, it is served between them (alternation).
- `d_pmem_read` and `d_pmem_write` asserted together is illegal. The arbiter forwards both unchanged; a bench assertion flags it.
- `mem_resp` while in `ARB_IDLE` is ignored and not forwarded.

## Timing
- Reset: state = `ARB_IDLE`, `last_grant` = 0. All command and resp outputs are 0, as are `mem_address` and `mem_wdata`.
- Grant latency: a request sampled in `ARB_IDLE` at edge N puts the state in serve from N+1. The downstream command is asserted in cycle N+1 (registered grant, one cycle of arbitration).
- Response path: `mem_resp` to cache resp is zero-cycle, combinational.
- Dead cycle: after completion, the arbiter spends one cycle in `ARB_IDLE` before the next grant. A back-to-back request from the same cache is therefore re-issued two cycles after the previous resp. The dead cycle also guarantees a requester's stale level request is never re-granted.
- Minimum transaction: 1 arbitration cycle + downstream latency + 1 idle cycle.
- Requester drops its request mid-grant: the command deasserts. The arbiter holds the grant until `mem_resp`; requesters must not drop early.
- Reset mid-transaction: return to `ARB_IDLE` on the next edge. Any later `mem_resp` is ignored, and the downstream model must be reset together with the arbiter.

## Structure
- Shared package `arbiter_types` holds:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ICACHE, ARB_DCACHE} arb_state_t`
  - `typedef enum logic {GRANT_I, GRANT_D} grant_t` for `last_grant`
- Line and address widths come from the existing cache parameters, not new constants.
- Single flat module with a state register, a `last_grant` register, next-state logic, and an output mux. No sub-module is warranted.

## Test plan
- Reset, then I read to 0x0000_0040 alone: `mem_read` rises one cycle later with address 0x40. Downstream resp with rdata 0xAA..AA gives `i_pmem_resp` for one cycle with that data, and `d_pmem_resp` stays 0.
- D write-back to 0x0000_1000 with wdata 0x55..55: `mem_write` = 1, `mem_wdata` = 0x55..55, and only `d_pmem_resp` pulses.
- I and D raise in the same cycle after reset: D is granted first. I is granted two cycles after D's resp, and the next simultaneous conflict goes to I.
- D dirty miss (write 0x2000, then read 0x3000) with I reading 0x0100 continuously: the order seen at memory is D-write, I-read, D-read.
- `rst` asserted while in `ARB_DCACHE` before `mem_resp`: next cycle the state is `ARB_IDLE` and all commands are 0. A `mem_resp` pulse two cycles later produces no cache resp.
- `mem_resp` pulsed while idle: both resp outputs stay 0 and the state is unchanged.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// pmem_arbiter_pkg: shared state and grant encodings for the pmem arbiter.
package arbiter_types;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ICACHE, ARB_DCACHE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: grants the single memory line port to the I-cache or D-cache, alternating on conflict.
module pmem_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);
  arb_state_t state_q, state_d;
  grant_t last_grant_q, last_grant_d;
  logic i_req, d_req, serve_i, serve_d;
  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign serve_i = state_q == ARB_ICACHE;
  assign serve_d = state_q == ARB_DCACHE;
  // on conflict the side not granted last time wins
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (state_q == ARB_IDLE) begin
      if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
        state_d      = ARB_ICACHE;
        last_grant_d = GRANT_I;
      end else if (d_req) begin
        state_d      = ARB_DCACHE;
        last_grant_d = GRANT_D;
      end
    end else if (mem_resp) begin
      state_d = ARB_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end
  always_comb begin
    mem_read    = serve_i ? i_pmem_read : serve_d ? d_pmem_read : 1'b0;
    mem_write   = serve_d ? d_pmem_write : 1'b0;
    mem_address = serve_i ? i_pmem_address : serve_d ? d_pmem_address : '0;
    mem_wdata   = serve_d ? d_pmem_wdata : '0;
  end
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = mem_resp & serve_i;
  assign d_pmem_resp  = mem_resp & serve_d;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: scoreboard bench with cache drivers, a downstream memory model and response monitor.
module tb_pmem_arbiter;
  import arbiter_types::*;
  localparam int LAT = 2;
  localparam logic [255:0] AA = {32{8'hAA}};
  localparam logic [255:0] FF55 = {32{8'h55}};
  localparam logic [255:0] R1 = {8{32'hD1D1_0001}};
  localparam logic [255:0] R2 = {8{32'h1C1C_0002}};
  localparam logic [255:0] R3 = {8{32'hD2D2_0003}};
  localparam logic [255:0] R4 = {8{32'h0B0B_0004}};
  localparam logic [255:0] R5 = {8{32'h0C0C_0005}};
  localparam logic [255:0] R6 = {8{32'h0D0D_0006}};
  localparam logic [255:0] WB = {8{32'hDEAD_BEEF}};

  typedef struct {
    logic d;
    logic wr;
    logic [31:0] addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int gap_req;
    int gap_resp;
  } mem_op_t;
  typedef struct {
    logic d;
    logic [255:0] data;
  } resp_t;
  typedef struct {
    logic wr;
    logic [31:0] addr;
    logic [255:0] wdata;
  } d_req_t;

  logic clk = 0, rst;
  logic i_pmem_read, i_pmem_resp, d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [31:0] i_pmem_address, d_pmem_address, mem_address;
  logic [255:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata, mem_wdata, mem_rdata;
  logic mem_read, mem_write, mem_resp, mem_resp_m, mem_resp_x;
  logic abort, mem_auto, i_busy, d_busy;
  int cyc = 0, i_raise = 0, d_raise = 0, last_resp = 0;
  int total = 0, passed = 0;
  mem_op_t mem_q[$];
  resp_t resp_q[$];
  logic [31:0] i_q[$];
  d_req_t d_q[$];

  pmem_arbiter #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_resp = mem_resp_m | mem_resp_x;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: got no event required one", name);
  endtask

  always @(negedge clk)
    if (!rst) assert (!(d_pmem_read && d_pmem_write)) else $error("d-cache read and write asserted together");

  initial begin
    i_pmem_read = 0; i_pmem_address = '0; i_busy = 0;
    forever begin
      @(posedge clk);
      if (i_q.size() != 0) begin
        int n;
        bit done;
        i_busy = 1; #1;
        i_pmem_address = i_q.pop_front(); i_pmem_read = 1; i_raise = cyc;
        n = 0; done = 0;
        while (!done) begin
          @(negedge clk); n++;
          if (i_pmem_resp || abort) begin
            @(posedge clk); #1;
            if (i_q.size() != 0 && !abort) begin
              i_pmem_address = i_q.pop_front(); i_raise = cyc; n = 0;
            end else begin
              i_pmem_read = 0; done = 1;
            end
          end else if (n > 200) begin
            fail("i_resp_timeout"); i_pmem_read = 0; done = 1;
          end
        end
        i_busy = 0;
      end
    end
  end

  initial begin
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0; d_busy = 0;
    forever begin
      @(posedge clk);
      if (d_q.size() != 0) begin
        int n;
        bit done;
        d_req_t r;
        d_busy = 1; #1;
        r = d_q.pop_front();
        d_pmem_read = !r.wr; d_pmem_write = r.wr; d_pmem_address = r.addr; d_pmem_wdata = r.wdata; d_raise = cyc;
        n = 0; done = 0;
        while (!done) begin
          @(negedge clk); n++;
          if (d_pmem_resp || abort) begin
            @(posedge clk); #1;
            if (d_q.size() != 0 && !abort) begin
              r = d_q.pop_front();
              d_pmem_read = !r.wr; d_pmem_write = r.wr; d_pmem_address = r.addr; d_pmem_wdata = r.wdata;
              d_raise = cyc; n = 0;
            end else begin
              d_pmem_read = 0; d_pmem_write = 0; done = 1;
            end
          end else if (n > 200) begin
            fail("d_resp_timeout"); d_pmem_read = 0; d_pmem_write = 0; done = 1;
          end
        end
        d_busy = 0;
      end
    end
  end

  // downstream memory: checks each command against the expected order, then answers after LAT cycles
  initial begin
    mem_op_t e;
    mem_resp_m = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && !rst && (mem_read || mem_write)) begin
        e = '{1'b0, 1'b0, 32'h0, 256'h0, 256'h0, -1, -1};
        if (mem_q.size() == 0) fail("mem_cmd_expected");
        else begin
          e = mem_q.pop_front();
          check("mem_read", 256'(mem_read), 256'(!e.wr));
          check("mem_write", 256'(mem_write), 256'(e.wr));
          check("mem_address", 256'(mem_address), 256'(e.addr));
          if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
          if (e.gap_req >= 0) check("grant_latency", 256'(cyc - (e.d ? d_raise : i_raise)), 256'(e.gap_req));
          if (e.gap_resp >= 0) check("dead_cycle_gap", 256'(cyc - last_resp), 256'(e.gap_resp));
        end
        repeat (LAT) @(posedge clk);
        #1 mem_rdata = e.rdata; mem_resp_m = 1; last_resp = cyc;
        @(posedge clk);
        #1 mem_resp_m = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (i_pmem_resp || d_pmem_resp) begin
      if (resp_q.size() == 0) fail("resp_expected");
      else begin
        resp_t r;
        r = resp_q.pop_front();
        check("resp_side", 256'({i_pmem_resp, d_pmem_resp}), r.d ? 256'(2'b01) : 256'(2'b10));
        check("resp_data", r.d ? d_pmem_rdata : i_pmem_rdata, r.data);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((i_q.size() != 0 || d_q.size() != 0 || i_busy || d_busy || mem_q.size() != 0 || resp_q.size() != 0) && n < 400) begin
      @(posedge clk); n++;
    end
    if (n >= 400) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; abort = 0; mem_auto = 1; mem_resp_x = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", 256'(mem_read), 256'(0));
    check("rst_mem_write", 256'(mem_write), 256'(0));
    check("rst_mem_address", 256'(mem_address), 256'(0));
    check("rst_mem_wdata", mem_wdata, 256'(0));
    check("rst_i_resp", 256'(i_pmem_resp), 256'(0));
    check("rst_d_resp", 256'(d_pmem_resp), 256'(0));
    check("rst_state", 256'(dut.state_q), 256'(ARB_IDLE));
    @(posedge clk); #1 rst = 0;
    // lone I-cache fill
    i_q.push_back(32'h0000_0040);
    mem_q.push_back('{1'b0, 1'b0, 32'h0000_0040, 256'h0, AA, 1, -1});
    resp_q.push_back('{1'b0, AA});
    drain();
    // lone D-cache write-back
    d_q.push_back('{1'b1, 32'h0000_1000, FF55});
    mem_q.push_back('{1'b1, 1'b1, 32'h0000_1000, FF55, R1, 1, -1});
    resp_q.push_back('{1'b1, R1});
    drain();
    // simultaneous requests after reset: D, then I, then D again
    rst = 1; repeat (2) @(posedge clk); #1 rst = 0;
    d_q.push_back('{1'b0, 32'h0000_0600, 256'h0});
    d_q.push_back('{1'b0, 32'h0000_0700, 256'h0});
    i_q.push_back(32'h0000_0500);
    mem_q.push_back('{1'b1, 1'b0, 32'h0000_0600, 256'h0, R2, 1, -1});
    mem_q.push_back('{1'b0, 1'b0, 32'h0000_0500, 256'h0, R3, -1, 2});
    mem_q.push_back('{1'b1, 1'b0, 32'h0000_0700, 256'h0, R4, -1, 2});
    resp_q.push_back('{1'b1, R2});
    resp_q.push_back('{1'b0, R3});
    resp_q.push_back('{1'b1, R4});
    drain();
    // dirty miss with I-cache pending: write-back, I fill, D fill
    d_q.push_back('{1'b1, 32'h0000_2000, WB});
    d_q.push_back('{1'b0, 32'h0000_3000, 256'h0});
    mem_q.push_back('{1'b1, 1'b1, 32'h0000_2000, WB, R5, 1, -1});
    mem_q.push_back('{1'b0, 1'b0, 32'h0000_0100, 256'h0, R6, -1, 2});
    mem_q.push_back('{1'b1, 1'b0, 32'h0000_3000, 256'h0, AA, -1, 2});
    resp_q.push_back('{1'b1, R5});
    resp_q.push_back('{1'b0, R6});
    resp_q.push_back('{1'b1, AA});
    @(posedge clk); #1 i_q.push_back(32'h0000_0100);
    drain();
    // reset during a D grant, then a stray downstream response
    mem_auto = 0;
    d_q.push_back('{1'b0, 32'h0000_4000, 256'h0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("grant_state_d", 256'(dut.state_q), 256'(ARB_DCACHE));
    check("grant_mem_read", 256'(mem_read), 256'(1));
    check("grant_mem_address", 256'(mem_address), 256'(32'h0000_4000));
    @(posedge clk); #1 rst = 1; abort = 1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_state", 256'(dut.state_q), 256'(ARB_IDLE));
    check("mid_rst_mem_read", 256'(mem_read), 256'(0));
    check("mid_rst_mem_write", 256'(mem_write), 256'(0));
    check("mid_rst_mem_address", 256'(mem_address), 256'(0));
    @(posedge clk); #1 rst = 0; abort = 0;
    @(posedge clk); #1 mem_resp_x = 1;
    @(negedge clk);
    check("idle_resp_i", 256'(i_pmem_resp), 256'(0));
    check("idle_resp_d", 256'(d_pmem_resp), 256'(0));
    @(posedge clk); #1 mem_resp_x = 0;
    @(negedge clk);
    check("idle_resp_state", 256'(dut.state_q), 256'(ARB_IDLE));
    check("idle_mem_read", 256'(mem_read), 256'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
